// File: rtl/binary_divider_sequential_if.sv
// ----------------------------------------------------------------------------
// binary_divider_sequential_if
//   Request/result bundle for the sequential restoring divider.
//   Parameter N : divisor/remainder width; dividend and quotient are 2N bits.
//   Signals:
//     start       requester -> divider  request, looked at only while idle
//     dividend    requester -> divider  2N-bit dividend, captured on accept
//     divisor     requester -> divider  N-bit divisor, captured on accept
//     busy        divider -> requester  high while iterating
//     done        divider -> requester  one-cycle pulse, results valid
//     quotient    divider -> requester  2N-bit result, held between operations
//     remainder   divider -> requester  N-bit result, held between operations
//     div_by_zero divider -> requester  flags a zero divisor, reported with done
//   Modports: master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface binary_divider_sequential_if #(
    parameter int N = 4
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/binary_divider_sequential.sv
// ----------------------------------------------------------------------------
// binary_divider_sequential
//   Sequential restoring divider: 2N-bit dividend / N-bit divisor, producing a
//   2N-bit quotient and N-bit remainder, one quotient bit per clock (2N steps).
//   A zero divisor short-circuits straight to the result cycle with an
//   all-ones quotient, zero remainder and div_by_zero set.
//   Ports:
//     clk  in  single clock, rising edge
//     rst  in  synchronous, active-high; aborts any operation, clears outputs
//     bus  slave modport of binary_divider_sequential_if (request/result)
// ----------------------------------------------------------------------------
module binary_divider_sequential #(
    parameter int N = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    binary_divider_sequential_if.slave     bus
);
    localparam int CNT_W = $clog2(2*N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   d_q,     d_d;      // dividend shift register
    logic [N-1:0]     v_q,     v_d;      // captured divisor
    logic [N-1:0]     r_q,     r_d;      // partial remainder (low N bits)
    logic [2*N-1:0]   qacc_q,  qacc_d;   // quotient being assembled
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2*N-1:0]   quot_q,  quot_d;
    logic [N-1:0]     rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    // The trial value is the N+1-bit partial remainder. Its top bit is always
    // zero between steps (a restored remainder is below the divisor), so only
    // the low N bits need storing.
    logic [N:0]       trial;
    logic [N-1:0]     diff;
    logic             ge;

    always_comb begin
        trial = {r_q, d_q[2*N-1]};
        ge    = (trial >= {1'b0, v_q});
        // Only consumed when trial >= divisor; the true difference is then
        // below the divisor, so the N-bit modular subtract is exact.
        diff  = trial[N-1:0] - v_q;
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        v_d     = v_q;
        r_d     = r_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        d_d     = bus.dividend;
                        v_d     = bus.divisor;
                        r_d     = '0;
                        qacc_d  = '0;
                        cnt_d   = CNT_W'(2*N);
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                d_d    = {d_q[2*N-2:0], 1'b0};
                r_d    = ge ? diff : trial[N-1:0];
                qacc_d = {qacc_q[2*N-2:0], ge};
                cnt_d  = cnt_q - CNT_W'(1);
                // Last step: publish the results from this step's values.
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = {qacc_q[2*N-2:0], ge};
                    rem_d   = ge ? diff : trial[N-1:0];
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            v_q     <= v_d;
            r_q     <= r_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
